// File: rtl/uart_tx_slave_if.sv
// Bus-side slave interface of the UART transmitter: the decoder's din/addr/we/dout bank signals.
interface uart_tx_slave_if #(
   parameter int DW = 16,
   parameter int AW = 13
);
   logic [DW-1:0] din;
   logic [AW-1:0] addr;
   logic          we;
   logic [DW-1:0] dout;

   modport master (output din, output addr, output we, input dout);
   modport slave  (input din, input addr, input we, output dout);
endinterface

// File: rtl/uart_tx_slave.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the 16-bit data bus.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_slave #(
   parameter int          DW      = 16,
   parameter int          AW      = 13,
   parameter int          FIFO_AW = 2,
   parameter logic [15:0] DIV_RST = 16'd433
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_slave_if.slave bus,
   output logic           uart_tx,
   output logic           tx_irq
);
   localparam int                 DEPTH     = 32'd1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   DEPTH_CNT = (FIFO_AW+1)'(32'd1 << FIFO_AW);
   localparam logic [FIFO_AW:0]   CNT_ZERO  = (FIFO_AW+1)'(1'b0);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1'b1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1'b1);
`ifdef UART_TX_PARITY_EN
   localparam logic               PAR_EN    = 1'b1;
`else
   localparam logic               PAR_EN    = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

   logic [7:0]         mem_r [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [FIFO_AW:0]   count_r, count_s;
   logic               ovf_r;
   logic [15:0]        baud_div_r;
   logic [DW-1:0]      dout_r;
   state_t             state_r, state_s;
   logic [15:0]        baud_cnt_r, baud_cnt_s, div_q_r, div_q_s;
   logic [2:0]         bit_cnt_r, bit_cnt_s;
   logic [7:0]         shift_r, shift_s;
   logic               par_r, par_s, pop_s, tx_r, tx_s, irq_r, irq_s;
   logic [1:0]         sel_s;
   logic               push_req_s, push_ok_s, full_s, empty_s;
   logic [7:0]         count_byte_s;
   logic [15:0]        status_s;

   assign sel_s        = bus.addr[1:0];
   assign full_s       = (count_r == DEPTH_CNT);
   assign empty_s      = (count_r == CNT_ZERO);
   assign push_req_s   = bus.we && (sel_s == 2'd0);
   // Full is judged on the pre-edge count, so a same-cycle pop never frees room for a push.
   assign push_ok_s    = push_req_s && !full_s;
   assign count_byte_s = 8'(count_r);
   assign status_s     = {count_byte_s, 3'b000, PAR_EN, ovf_r, (state_r != S_IDLE), full_s, empty_s};
   assign bus.dout     = dout_r;
   assign uart_tx      = tx_r;
   assign tx_irq       = irq_r;

   // Frame sequencer: next state, bit timing and FIFO pop decision.
   always_comb begin
      state_s    = state_r;
      baud_cnt_s = baud_cnt_r;
      bit_cnt_s  = bit_cnt_r;
      shift_s    = shift_r;
      div_q_s    = div_q_r;
      par_s      = par_r;
      pop_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               state_s = S_START;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_START: begin
            if (baud_cnt_r == div_q_r) begin
               state_s    = S_DATA;
               baud_cnt_s = 16'd0;
               bit_cnt_s  = 3'd0;
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         S_DATA: begin
            if (baud_cnt_r == div_q_r) begin
               baud_cnt_s = 16'd0;
               if (bit_cnt_r == 3'd7) begin
                  state_s = PAR_EN ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_s = bit_cnt_r + 3'd1;
                  shift_s   = {1'b0, shift_r[7:1]};
               end
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         S_PARITY: begin
            if (baud_cnt_r == div_q_r) begin
               state_s    = S_STOP;
               baud_cnt_s = 16'd0;
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         S_STOP: begin
            if (baud_cnt_r == div_q_r) begin
               if (!empty_s) begin
                  pop_s   = 1'b1;
                  state_s = S_START;
               end else begin
                  state_s = S_IDLE;
               end
            end else begin
               baud_cnt_s = baud_cnt_r + 16'd1;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
      if (pop_s) begin
         shift_s    = mem_r[rd_ptr_r];
         par_s      = even_parity(mem_r[rd_ptr_r]);
         div_q_s    = baud_div_r;
         baud_cnt_s = 16'd0;
         bit_cnt_s  = 3'd0;
      end else begin
         par_s = par_r;
      end
   end

   // Next FIFO occupancy, line level and interrupt, derived from next state so outputs are registered.
   always_comb begin
      count_s = count_r;
      tx_s    = 1'b1;
      case ({push_ok_s, pop_s})
         2'b10:   count_s = count_r + CNT_ONE;
         2'b01:   count_s = count_r - CNT_ONE;
         default: count_s = count_r;
      endcase
      case (state_s)
         S_IDLE:   tx_s = 1'b1;
         S_START:  tx_s = 1'b0;
         S_DATA:   tx_s = shift_s[0];
         S_PARITY: tx_s = par_s;
         S_STOP:   tx_s = 1'b1;
         default:  tx_s = 1'b1;
      endcase
      irq_s = (state_s == S_IDLE) && (count_s == CNT_ZERO);
   end

   // Sequencer state and serial outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= S_IDLE;
         baud_cnt_r <= 16'd0;
         bit_cnt_r  <= 3'd0;
         shift_r    <= 8'd0;
         div_q_r    <= 16'd0;
         par_r      <= 1'b0;
         tx_r       <= 1'b1;
         irq_r      <= 1'b1;
      end else begin
         state_r    <= state_s;
         baud_cnt_r <= baud_cnt_s;
         bit_cnt_r  <= bit_cnt_s;
         shift_r    <= shift_s;
         div_q_r    <= div_q_s;
         par_r      <= par_s;
         tx_r       <= tx_s;
         irq_r      <= irq_s;
      end
   end

   // FIFO storage; contents need no reset because occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= bus.din[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= CNT_ZERO;
         ovf_r    <= 1'b0;
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s)     rd_ptr_r <= rd_ptr_r + PTR_ONE;
         count_r <= count_s;
         if (push_req_s && full_s) begin
            ovf_r <= 1'b1;
         end else if (bus.we && (sel_s == 2'd1) && bus.din[3]) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Baud divisor register; a running frame keeps its latched copy in div_q_r.
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_div_r <= DIV_RST;
      end else if (bus.we && (sel_s == 2'd2)) begin
         baud_div_r <= bus.din;
      end
   end

   // Registered read port; writes also refresh dout with the addressed register's old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout_r <= 16'h0000;
      end else begin
         case (sel_s)
            2'd1:    dout_r <= status_s;
            2'd2:    dout_r <= baud_div_r;
            default: dout_r <= 16'h0000;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_slave.sv
// Directed self-checking bench for uart_tx_slave: register map, frame timing, FIFO limits, reset abort.
module tb_uart_tx_slave;
`ifdef UART_TX_PARITY_EN
   localparam int          NBITS  = 11;
   localparam logic [15:0] ST_PAR = 16'h0010;
`else
   localparam int          NBITS  = 10;
   localparam logic [15:0] ST_PAR = 16'h0000;
`endif
   localparam logic [15:0] ST_IDLE = 16'h0001 | ST_PAR;
   localparam int          WAIT_MAX = 2000;

   logic clk = 1'b0;
   logic rst;
   logic uart_tx, tx_irq;
   int   tests_run = 0;
   int   tests_failed = 0;
   logic [15:0] rd;

   uart_tx_slave_if bus ();

   uart_tx_slave dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave),
      .uart_tx (uart_tx),
      .tx_irq  (tx_irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All bus tasks are entered and left on a falling edge.
   task automatic bus_write(input logic [12:0] a, input logic [15:0] d);
      bus.we = 1'b1; bus.addr = a; bus.din = d;
      @(negedge clk);
      bus.we = 1'b0;
   endtask

   task automatic bus_read(input logic [12:0] a, output logic [15:0] d);
      bus.we = 1'b0; bus.addr = a;
      @(negedge clk);
      d = bus.dout;
   endtask

   task automatic rx_frame(input int div, output logic [10:0] bits, output logic stable, output int gap);
      bits = 11'd0; stable = 1'b1; gap = 0;
      @(negedge clk);
      while (uart_tx !== 1'b0 && gap < WAIT_MAX) begin
         @(negedge clk);
         gap++;
      end
      for (int b = 0; b < NBITS; b++) begin
         for (int c = 0; c <= div; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) bits[b] = uart_tx;
            else if (uart_tx !== bits[b]) stable = 1'b0;
         end
      end
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] data, input int div, input bit b2b);
      logic [10:0] bits, exp;
      logic        stable;
      int          gap;
      rx_frame(div, bits, stable, gap);
`ifdef UART_TX_PARITY_EN
      exp = {1'b1, ^data, data, 1'b0};
`else
      exp = {1'b0, 1'b1, data, 1'b0};
`endif
      check_eq({tag, "_timeout"}, 32'(gap < WAIT_MAX), 32'd1);
      if (b2b) check_eq({tag, "_gap"}, 32'(gap), 32'd0);
      check_eq({tag, "_bits"}, 32'(bits), 32'(exp));
      check_eq({tag, "_stable"}, 32'(stable), 32'd1);
   endtask

   initial begin
      int n, lows;
      rst = 1'b1; bus.we = 1'b0; bus.addr = 13'd0; bus.din = 16'd0;

      // 1: reset state and register map
      @(negedge clk);
      check_eq("rst_dout", 32'(bus.dout), 32'h0);
      check_eq("rst_tx", 32'(uart_tx), 32'd1);
      check_eq("rst_irq", 32'(tx_irq), 32'd1);
      rst = 1'b0;
      bus_read(13'd1, rd);  check_eq("status_idle", 32'(rd), 32'(ST_IDLE));
      bus_read(13'd2, rd);  check_eq("baud_rst", 32'(rd), 32'd433);
      bus_read(13'd3, rd);  check_eq("reserved_rd", 32'(rd), 32'h0);
      bus_read(13'd0, rd);  check_eq("txdata_rd", 32'(rd), 32'h0);
      bus_read(13'h1005, rd); check_eq("alias_status", 32'(rd), 32'(ST_IDLE));

      // 2: single 0x55 frame at 4 clks per bit
      bus_write(13'd2, 16'd3);
      check_eq("wr_old_dout", 32'(bus.dout), 32'd433);
      bus_read(13'd2, rd);  check_eq("baud_3", 32'(rd), 32'd3);
      bus_write(13'd0, 16'h0055);
      expect_frame("f55", 8'h55, 3, 1'b0);
      repeat (2) @(negedge clk);
      check_eq("f55_irq", 32'(tx_irq), 32'd1);
      bus_read(13'd1, rd);  check_eq("f55_status", 32'(rd), 32'(ST_IDLE));

      // 3: five back-to-back frames at one clk per bit
      bus_write(13'd2, 16'd0);
      fork
         begin
            bus_write(13'd0, 16'h00A1);
            bus_write(13'd0, 16'h003C);
            bus_write(13'd0, 16'h00FF);
            bus_write(13'd0, 16'h0000);
            bus_write(13'd0, 16'h0096);
         end
         begin
            expect_frame("b2b0", 8'hA1, 0, 1'b0);
            expect_frame("b2b1", 8'h3C, 0, 1'b1);
            expect_frame("b2b2", 8'hFF, 0, 1'b1);
            expect_frame("b2b3", 8'h00, 0, 1'b1);
            expect_frame("b2b4", 8'h96, 0, 1'b1);
         end
      join
      repeat (2) @(negedge clk);
      bus_read(13'd1, rd);  check_eq("b2b_status", 32'(rd), 32'(ST_IDLE));

      // 4: overflow with a slow divisor
      bus_write(13'd2, 16'd100);
      for (int i = 0; i < 6; i++) bus_write(13'd0, 16'(8'h11 + i));
      bus_read(13'd1, rd);  check_eq("ovf_status", 32'(rd), 32'(16'h040E | ST_PAR));
      bus_write(13'd1, 16'h0000);
      bus_read(13'd1, rd);  check_eq("ovf_keep", 32'(rd), 32'(16'h040E | ST_PAR));
      bus_write(13'd1, 16'h0008);
      bus_read(13'd1, rd);  check_eq("ovf_clear", 32'(rd), 32'(16'h0406 | ST_PAR));
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      bus_read(13'd1, rd);  check_eq("ovf_rst_status", 32'(rd), 32'(ST_IDLE));

      // 5: divisor change mid-frame applies to the next frame only
      bus_write(13'd2, 16'd3);
      fork
         begin
            bus_write(13'd0, 16'h000F);
            bus_write(13'd0, 16'h00F0);
            repeat (10) @(negedge clk);
            bus_write(13'd2, 16'd7);
         end
         begin
            expect_frame("div3", 8'h0F, 3, 1'b0);
            expect_frame("div7", 8'hF0, 7, 1'b1);
         end
      join

      // 6: reset during data bit 3 aborts the frame and flushes the FIFO
      repeat (2) @(negedge clk);
      bus_write(13'd2, 16'd3);
      bus_write(13'd0, 16'h005A);
      bus_write(13'd0, 16'h00C3);
      n = 0;
      while (uart_tx !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("abort_start_seen", 32'(n < 100), 32'd1);
      repeat (18) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_tx", 32'(uart_tx), 32'd1);
      check_eq("abort_irq", 32'(tx_irq), 32'd1);
      check_eq("abort_dout", 32'(bus.dout), 32'h0);
      rst = 1'b0;
      bus_read(13'd1, rd);  check_eq("abort_status", 32'(rd), 32'(ST_IDLE));
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      check_eq("abort_line_idle", 32'(lows), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
